// File: rtl/max_unpool.sv
// Max-unpool for one 4x4 tile: captures argmax per 2x2 window on the forward
// stream, then scatters the four pooled gradients back to their argmax positions.

module max_unpool_win #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [1:0]               cap_p,
  input  logic signed [DATA_W-1:0] cap_data,
  input  logic                     grad_en,
  input  logic signed [DATA_W-1:0] grad_in,
  input  logic [1:0]               qry_p,
  output logic signed [DATA_W-1:0] val
);
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] gr;
  logic [1:0]               arg;

  // p==0 opens the window; >= lets later ties win, matching forward max-pool.
  always_ff @(posedge clk) begin
    if (rst) begin
      mx  <= '0;
      arg <= '0;
      gr  <= '0;
    end else begin
      if (cap_en && ((cap_p == 2'd0) || (cap_data >= mx))) begin
        mx  <= cap_data;
        arg <= cap_p;
      end
      if (grad_en) gr <= grad_in;
    end
  end

  assign val = (qry_p == arg) ? gr : '0;
endmodule

module max_unpool #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic signed [DATA_W-1:0] fwd_data,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic signed [DATA_W-1:0] grad_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int NUM_WIN = 4;

  typedef enum logic [1:0] {CAPTURE, GRAD, EMIT} state_t;

  state_t state, nxt;
  logic [3:0] idx;
  logic [1:0] gidx;
  logic       fwd_xfer, grad_xfer, out_xfer;
  logic [1:0] cur_w, cur_p;
  logic [NUM_WIN-1:0][DATA_W-1:0] win_val;

  assign fwd_xfer  = fwd_valid  && fwd_ready;
  assign grad_xfer = grad_valid && grad_ready;
  assign out_xfer  = out_valid  && out_ready;

  // idx serves both capture and emit; the phases never overlap.
  assign cur_w = {idx[3], idx[1]};
  assign cur_p = {idx[2], idx[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAPTURE;
      idx   <= '0;
      gidx  <= '0;
    end else begin
      state <= nxt;
      if (fwd_xfer || out_xfer) idx <= idx + 4'd1;
      if (grad_xfer)            gidx <= gidx + 2'd1;
    end
  end

  always_comb begin
    nxt        = state;
    fwd_ready  = 1'b0;
    grad_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    out_data   = '0;
    case (state)
      CAPTURE: begin
        fwd_ready = 1'b1;
        busy      = 1'b0;
        if (fwd_xfer && (idx == 4'd15)) nxt = GRAD;
      end
      GRAD: begin
        grad_ready = 1'b1;
        if (grad_xfer && (gidx == 2'd3)) nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (idx == 4'd15);
        out_data  = win_val[cur_w];
        if (out_xfer && (idx == 4'd15)) nxt = CAPTURE;
      end
      default: nxt = CAPTURE;
    endcase
  end

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    max_unpool_win #(.DATA_W(DATA_W)) u_win (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (fwd_xfer && (cur_w == 2'(w))),
      .cap_p    (cur_p),
      .cap_data (fwd_data),
      .grad_en  (grad_xfer && (gidx == 2'(w))),
      .grad_in  (grad_data),
      .qry_p    (cur_p),
      .val      (win_val[w])
    );
  end
endmodule

// File: tb/tb_max_unpool.sv
// Directed bench for max_unpool: hand-computed tiles, stalls, mid-tile reset,
// and a full-rate streaming tile with all valids held high.

module tb_max_unpool;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic fwd_valid, grad_valid, out_ready;
  logic fwd_ready, grad_ready, out_valid, out_last, busy;
  logic signed [DW-1:0] fwd_data, grad_data, out_data;

  logic signed [DW-1:0] fv [16];
  logic signed [DW-1:0] gv [4];
  logic signed [DW-1:0] ex [16];
  logic signed [DW-1:0] od [16];
  logic                 ol [16];
  int fcnt, gcnt, ocnt;
  int n_chk = 0, n_pass = 0;
  logic st_prev = 1'b0;
  logic signed [DW-1:0] hd;
  logic hl;

  max_unpool #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change at posedge+1; monitor looks at negedge, ahead of the edge that transfers.
  always @(negedge clk) begin
    if (fwd_valid && fwd_ready)   fcnt++;
    if (grad_valid && grad_ready) gcnt++;
    if (st_prev) begin
      chk("hold_data", out_data, hd);
      chk("hold_last", out_last, hl);
    end
    st_prev = out_valid && !out_ready;
    hd = out_data;
    hl = out_last;
    if (out_valid && out_ready) begin
      if (ocnt < 16) begin
        od[ocnt] = out_data;
        ol[ocnt] = out_last;
      end
      ocnt++;
    end
  end

  task automatic drive_fwd(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      fwd_valid = 1'b1;
      fwd_data  = fv[i];
      @(negedge clk);
      while (!fwd_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin chk("fwd_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    fwd_valid = 1'b0;
  endtask

  task automatic drive_grad();
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      grad_valid = 1'b1;
      grad_data  = gv[i];
      @(negedge clk);
      while (!grad_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin chk("grad_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    grad_valid = 1'b0;
  endtask

  task automatic drain(input bit stall);
    int c = 0;
    ocnt = 0;
    while (ocnt < 16 && c < 300) begin
      out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    if (ocnt < 16) chk("out_timeout", ocnt, 16);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_d%0d", tag, i), od[i], ex[i]);
      chk($sformatf("%s_l%0d", tag, i), ol[i], (i == 15));
    end
  endtask

  task automatic set_ex(input int i0, input int v0, input int i1, input int v1,
                        input int i2, input int v2, input int i3, input int v3);
    for (int i = 0; i < 16; i++) ex[i] = '0;
    ex[i0] = v0; ex[i1] = v1; ex[i2] = v2; ex[i3] = v3;
  endtask

  task automatic load_t1();
    for (int i = 0; i < 16; i++) fv[i] = i + 1;
    gv = '{10, 20, 30, 40};
    set_ex(5, 10, 7, 20, 13, 30, 15, 40);
  endtask

  task automatic load_t3();
    fv = '{-5, -9, 3, -1, -2, -8, 3, 0, -1, -1, 9, 1, -1, -1, 2, 3};
    gv = '{100, 200, 300, 400};
    set_ex(4, 100, 6, 200, 13, 300, 10, 400);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fwd_valid = 1'b0; grad_valid = 1'b0; out_ready = 1'b0;
    fwd_data = '0; grad_data = '0;
    fcnt = 0; gcnt = 0; ocnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fwd_ready", fwd_ready, 1);
    chk("rst_grad_ready", grad_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // raster ramp: max at bottom-right of each window
    load_t1();
    drive_fwd(16);
    @(negedge clk);
    chk("grad_busy", busy, 1);
    chk("grad_fwd_ready", fwd_ready, 0);
    chk("grad_ready", grad_ready, 1);
    @(posedge clk); #1;
    drive_grad();
    drain(1'b0);
    check_out("t1");

    // all ties: later sample wins
    for (int i = 0; i < 16; i++) fv[i] = 7;
    gv = '{-1, -2, -3, -4};
    set_ex(5, -1, 7, -2, 13, -3, 15, -4);
    drive_fwd(16); drive_grad(); drain(1'b0);
    check_out("tie");

    // signed compare, mixed argmax positions
    load_t3();
    drive_fwd(16); drive_grad(); drain(1'b0);
    check_out("sgn");

    // stalled output must match the unstalled ramp result
    load_t1();
    drive_fwd(16); drive_grad(); drain(1'b1);
    check_out("stall");

    // reset after 9 samples discards the partial tile
    for (int i = 0; i < 16; i++) fv[i] = 1000;
    drive_fwd(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_fwd_ready", fwd_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    @(posedge clk); #1;
    load_t3();
    drive_fwd(16); drive_grad(); drain(1'b0);
    check_out("mrst");

    // all valids and out_ready held high: exactly 16/4/16 in 36 clocks
    load_t1();
    fcnt = 0; gcnt = 0; ocnt = 0;
    fwd_valid = 1'b1; grad_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      fwd_data  = fv[(fcnt < 16) ? fcnt : 0];
      grad_data = gv[(gcnt < 4) ? gcnt : 0];
      @(posedge clk); #1;
    end
    fwd_valid = 1'b0; grad_valid = 1'b0; out_ready = 1'b0;
    chk("strm_fwd_cnt", fcnt, 16);
    chk("strm_grad_cnt", gcnt, 4);
    chk("strm_out_cnt", ocnt, 16);
    @(negedge clk);
    chk("strm_back_capture", fwd_ready, 1);
    check_out("strm");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
